multi_circle_renderer: RTL and testbench

Pipelined N-slot circle compositor for the VGA pixel path. Each slot holds centre, radius and colour, and is loaded through a config handshake into a shadow bank. The shadow bank is copied to the active bank at frame start, so the image never tears mid-frame. Each pixel is tested against all active slots in parallel; the lowest-index hit sets the output colour, otherwise the background colour is used. A global beat offset is added to every radius for audio-driven pulsing.

---
 rtl/circle_pkg.sv | 42 ++++
 rtl/multi_circle_renderer_if.sv | 55 +++++
 rtl/circle_hit_pipe.sv | 102 ++++++++++
 rtl/multi_circle_renderer.sv | 163 ++++++++++++++++
 tb/tb_multi_circle_renderer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/circle_pkg.sv
// Shared widths, payload types, config FSM states and saturating helpers for the circle compositor.
// Build macro RING_MODE_EN adds a per-slot ring thickness field.
package circle_pkg;

    localparam int unsigned CW   = 11;
    localparam int unsigned RW   = 11;
    localparam int unsigned OFFW = 5;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic          en;
        logic [CW-1:0] center_X;
        logic [CW-1:0] center_Y;
        logic [RW-1:0] radius;
        rgb_t          color;
`ifdef RING_MODE_EN
        logic [RW-1:0] thick;
`endif
    } slot_t;

    typedef enum logic {IDLE, CLEAR} cfg_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [RW-1:0] sat_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[RW] ? {RW{1'b1}} : s[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] sat_sub(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/multi_circle_renderer_if.sv
// Config handshake and pixel stream bundle of the circle compositor.
// Build macro RING_MODE_EN adds the i_cfg_thick field.
interface multi_circle_renderer_if #(
    parameter int unsigned N_SLOTS = 8
);
    import circle_pkg::*;

    localparam int unsigned IDXW = idx_w(N_SLOTS);

    logic            i_cfg_valid;
    logic            o_cfg_ready;
    logic [IDXW-1:0] i_cfg_idx;
    logic            i_cfg_en;
    logic [CW-1:0]   i_cfg_center_X;
    logic [CW-1:0]   i_cfg_center_Y;
    logic [RW-1:0]   i_cfg_radius;
    logic [23:0]     i_cfg_color;
`ifdef RING_MODE_EN
    logic [RW-1:0]   i_cfg_thick;
`endif
    logic            i_cfg_clear;
    logic            i_frame_start;
    logic [OFFW-1:0] i_radius_off;
    logic [23:0]     i_bg_color;
    logic            i_pix_valid;
    logic [CW-1:0]   i_VGA_X;
    logic [CW-1:0]   i_VGA_Y;
    logic            o_pix_valid;
    logic [7:0]      o_VGA_R;
    logic [7:0]      o_VGA_G;
    logic [7:0]      o_VGA_B;
    logic            o_hit;
    logic [IDXW-1:0] o_hit_idx;

    modport slave (
`ifdef RING_MODE_EN
        input  i_cfg_thick,
`endif
        input  i_cfg_valid, i_cfg_idx, i_cfg_en, i_cfg_center_X, i_cfg_center_Y,
        input  i_cfg_radius, i_cfg_color, i_cfg_clear, i_frame_start, i_radius_off,
        input  i_bg_color, i_pix_valid, i_VGA_X, i_VGA_Y,
        output o_cfg_ready, o_pix_valid, o_VGA_R, o_VGA_G, o_VGA_B, o_hit, o_hit_idx
    );

    modport master (
`ifdef RING_MODE_EN
        output i_cfg_thick,
`endif
        output i_cfg_valid, i_cfg_idx, i_cfg_en, i_cfg_center_X, i_cfg_center_Y,
        output i_cfg_radius, i_cfg_color, i_cfg_clear, i_frame_start, i_radius_off,
        output i_bg_color, i_pix_valid, i_VGA_X, i_VGA_Y,
        input  o_cfg_ready, o_pix_valid, o_VGA_R, o_VGA_G, o_VGA_B, o_hit, o_hit_idx
    );

endinterface

// File: rtl/circle_hit_pipe.sv
// Per-slot circle membership test: S1 deltas and effective radius, S2 squares, S3 compare (combinational out).
// Build macro RING_MODE_EN adds the inner-radius exclusion.
module circle_hit_pipe
    import circle_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  slot_t           i_slot,
    input  logic [OFFW-1:0] i_off,
    input  logic [CW-1:0]   i_x,
    input  logic [CW-1:0]   i_y,
    output logic            o_hit_c,
    output rgb_t            o_color
);
    localparam int unsigned DW = 2 * (CW + 1);
    localparam int unsigned SW = DW + 1;
    localparam int unsigned QW = 2 * RW;

    logic signed [CW:0] w_dx;
    logic signed [CW:0] w_dy;
    logic [RW-1:0]      w_reff;

    logic signed [CW:0] r1_dx;
    logic signed [CW:0] r1_dy;
    logic [RW-1:0]      r1_reff;
    logic               r1_en;
    rgb_t               r1_color;

    logic signed [DW-1:0] w_dx_ext;
    logic signed [DW-1:0] w_dy_ext;

    logic [DW-1:0] r2_dx2;
    logic [DW-1:0] r2_dy2;
    logic [QW-1:0] r2_r2;
    logic          r2_en;
    rgb_t          r2_color;

    logic [SW-1:0] w_d2;

    assign w_dx   = $signed({1'b0, i_x}) - $signed({1'b0, i_slot.center_X});
    assign w_dy   = $signed({1'b0, i_y}) - $signed({1'b0, i_slot.center_Y});
    assign w_reff = sat_add(i_slot.radius, RW'(i_off));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r1_dx    <= '0;
            r1_dy    <= '0;
            r1_reff  <= '0;
            r1_en    <= 1'b0;
            r1_color <= '0;
        end else begin
            r1_dx    <= w_dx;
            r1_dy    <= w_dy;
            r1_reff  <= w_reff;
            r1_en    <= i_slot.en;
            r1_color <= i_slot.color;
        end
    end

    assign w_dx_ext = DW'(r1_dx);
    assign w_dy_ext = DW'(r1_dy);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r2_dx2   <= '0;
            r2_dy2   <= '0;
            r2_r2    <= '0;
            r2_en    <= 1'b0;
            r2_color <= '0;
        end else begin
            r2_dx2   <= w_dx_ext * w_dx_ext;
            r2_dy2   <= w_dy_ext * w_dy_ext;
            r2_r2    <= QW'(r1_reff) * QW'(r1_reff);
            r2_en    <= r1_en;
            r2_color <= r1_color;
        end
    end

    // Distance sum kept one bit wider than either square so it never wraps.
    assign w_d2    = SW'(r2_dx2) + SW'(r2_dy2);
    assign o_color = r2_color;

`ifdef RING_MODE_EN
    logic [RW-1:0] r1_rin;
    logic [QW-1:0] r2_rin2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r1_rin  <= '0;
            r2_rin2 <= '0;
        end else begin
            r1_rin  <= sat_sub(w_reff, i_slot.thick);
            r2_rin2 <= QW'(r1_rin) * QW'(r1_rin);
        end
    end

    assign o_hit_c = r2_en && (w_d2 <= SW'(r2_r2)) && (w_d2 > SW'(r2_rin2));
`else
    assign o_hit_c = r2_en && (w_d2 <= SW'(r2_r2));
`endif

endmodule

// File: rtl/multi_circle_renderer.sv
// N-slot circle compositor: shadow/active slot banks, config FSM, per-slot hit pipes, priority colour mux.
// Build macro RING_MODE_EN turns slots into rings with a configurable thickness.
module multi_circle_renderer
    import circle_pkg::*;
#(
    parameter int unsigned N_SLOTS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    multi_circle_renderer_if.slave bus
);
    localparam int unsigned IDXW = idx_w(N_SLOTS);

    slot_t           r_shadow [N_SLOTS];
    slot_t           r_active [N_SLOTS];
    logic [OFFW-1:0] r_off;

    cfg_state_e      r_state;
    cfg_state_e      w_state_nxt;
    logic [IDXW-1:0] r_clr_idx;
    logic [IDXW-1:0] w_clr_idx_nxt;
    logic            r_cfg_ready;
    logic            w_wr_en;
    logic            w_clr_en;
    slot_t           w_wr_slot;

    logic            w_hit   [N_SLOTS];
    rgb_t            w_color [N_SLOTS];
    logic            w_any;
    logic [IDXW-1:0] w_idx;
    rgb_t            w_sel;

    logic            r_v1;
    logic            r_v2;
    logic            r_pix_valid;
    logic            r_hit;
    logic [IDXW-1:0] r_hit_idx;
    rgb_t            r_rgb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_clr_idx   <= '0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_idx   <= w_clr_idx_nxt;
            r_cfg_ready <= (w_state_nxt == IDLE);
        end
    end

    // Clear outranks a same-cycle write; out-of-range indices are accepted and dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_wr_en       = 1'b0;
        w_clr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_cfg_clear) begin
                    w_state_nxt   = CLEAR;
                    w_clr_idx_nxt = '0;
                end else if (bus.i_cfg_valid && r_cfg_ready && (32'(bus.i_cfg_idx) < N_SLOTS)) begin
                    w_wr_en = 1'b1;
                end
            end
            CLEAR: begin
                w_clr_en = 1'b1;
                if (32'(r_clr_idx) == N_SLOTS - 1) begin
                    w_state_nxt   = IDLE;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + IDXW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_wr_slot          = '0;
        w_wr_slot.en       = bus.i_cfg_en;
        w_wr_slot.center_X = bus.i_cfg_center_X;
        w_wr_slot.center_Y = bus.i_cfg_center_Y;
        w_wr_slot.radius   = bus.i_cfg_radius;
        w_wr_slot.color    = rgb_t'(bus.i_cfg_color);
`ifdef RING_MODE_EN
        w_wr_slot.thick    = bus.i_cfg_thick;
`endif
    end

    // Frame start copies the pre-write shadow, so a coincident write lands one frame later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_off <= '0;
        end else begin
            if (w_wr_en) r_shadow[bus.i_cfg_idx] <= w_wr_slot;
            if (w_clr_en) r_shadow[r_clr_idx].en <= 1'b0;
            if (bus.i_frame_start) begin
                r_active <= r_shadow;
                r_off    <= bus.i_radius_off;
            end
        end
    end

    for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_slot
        circle_hit_pipe u_pipe (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_slot  (r_active[g]),
            .i_off   (r_off),
            .i_x     (bus.i_VGA_X),
            .i_y     (bus.i_VGA_Y),
            .o_hit_c (w_hit[g]),
            .o_color (w_color[g])
        );
    end

    // Scan high to low so the lowest hitting index wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sel = rgb_t'(bus.i_bg_color);
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_idx = IDXW'(i);
                w_sel = w_color[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_pix_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_rgb       <= '0;
        end else begin
            r_v1        <= bus.i_pix_valid;
            r_v2        <= r_v1;
            r_pix_valid <= r_v2;
            r_hit       <= r_v2 && w_any;
            r_hit_idx   <= (r_v2 && w_any) ? w_idx : '0;
            r_rgb       <= r_v2 ? w_sel : '0;
        end
    end

    assign bus.o_cfg_ready = r_cfg_ready;
    assign bus.o_pix_valid = r_pix_valid;
    assign bus.o_hit       = r_hit;
    assign bus.o_hit_idx   = r_hit_idx;
    assign bus.o_VGA_R     = r_rgb.r;
    assign bus.o_VGA_G     = r_rgb.g;
    assign bus.o_VGA_B     = r_rgb.b;

endmodule

// File: tb/tb_multi_circle_renderer.sv
// Directed bench for multi_circle_renderer with hand-computed expected pixels and handshake timings.
module tb_multi_circle_renderer;
    import circle_pkg::*;

    localparam int unsigned NS  = 8;
    localparam logic [23:0] BG  = 24'h102030;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] BLU = 24'h0000FF;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   w;
    int   cnt;

    always #5 clk = ~clk;

    multi_circle_renderer_if #(.N_SLOTS(NS)) bus ();

    multi_circle_renderer #(.N_SLOTS(NS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic en, input int cx, input int cy, input int r,
                      input logic [23:0] col, output int waits);
        waits = 0;
        bus.i_cfg_valid    = 1'b1;
        bus.i_cfg_idx      = idx[2:0];
        bus.i_cfg_en       = en;
        bus.i_cfg_center_X = 11'(cx);
        bus.i_cfg_center_Y = 11'(cy);
        bus.i_cfg_radius   = 11'(r);
        bus.i_cfg_color    = col;
        while (!bus.o_cfg_ready && waits < 40) begin
            tick();
            waits++;
        end
        tick();
        bus.i_cfg_valid = 1'b0;
    endtask

    task automatic frame(input int off);
        bus.i_frame_start = 1'b1;
        bus.i_radius_off  = 5'(off);
        tick();
        bus.i_frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic hit,
                       input int idx, input logic [23:0] rgb);
        bus.i_pix_valid = 1'b1;
        bus.i_VGA_X     = 11'(x);
        bus.i_VGA_Y     = 11'(y);
        tick();
        bus.i_pix_valid = 1'b0;
        tick();
        tick();
        chk({tag, ".vld"}, 32'(bus.o_pix_valid), 32'd1);
        chk({tag, ".hit"}, 32'(bus.o_hit), 32'(hit));
        chk({tag, ".idx"}, 32'(bus.o_hit_idx), 32'(idx));
        chk({tag, ".rgb"}, 32'({bus.o_VGA_R, bus.o_VGA_G, bus.o_VGA_B}), 32'(rgb));
    endtask

    initial begin
        bus.i_cfg_valid    = 1'b0;
        bus.i_cfg_idx      = '0;
        bus.i_cfg_en       = 1'b0;
        bus.i_cfg_center_X = '0;
        bus.i_cfg_center_Y = '0;
        bus.i_cfg_radius   = '0;
        bus.i_cfg_color    = '0;
`ifdef RING_MODE_EN
        bus.i_cfg_thick    = 11'h7FF;
`endif
        bus.i_cfg_clear    = 1'b0;
        bus.i_frame_start  = 1'b0;
        bus.i_radius_off   = '0;
        bus.i_bg_color     = BG;
        bus.i_pix_valid    = 1'b0;
        bus.i_VGA_X        = '0;
        bus.i_VGA_Y        = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst.ready", 32'(bus.o_cfg_ready), 32'd1);
        chk("rst.vld", 32'(bus.o_pix_valid), 32'd0);
        chk("rst.hit", 32'(bus.o_hit), 32'd0);
        chk("rst.rgb", 32'({bus.o_VGA_R, bus.o_VGA_G, bus.o_VGA_B}), 32'd0);
        rst = 1'b0;
        tick();

        // Single disc
        wr(0, 1'b1, 100, 100, 10, RED, w);
        frame(0);
        pix("basic.in", 105, 105, 1'b1, 0, RED);
        pix("basic.out", 108, 108, 1'b0, 0, BG);

        // Overlap priority
        wr(0, 1'b0, 100, 100, 10, RED, w);
        wr(1, 1'b1, 100, 100, 20, GRN, w);
        wr(3, 1'b1, 100, 100, 5, BLU, w);
        frame(0);
        pix("ovl.ctr", 100, 100, 1'b1, 1, GRN);
        pix("ovl.edge", 118, 100, 1'b1, 1, GRN);
        pix("ovl.out", 121, 100, 1'b0, 0, BG);

        // Global offset, negative deltas, saturation
        wr(1, 1'b0, 100, 100, 20, GRN, w);
        wr(3, 1'b0, 100, 100, 5, BLU, w);
        wr(0, 1'b1, 100, 100, 10, RED, w);
        frame(5);
        pix("off.edge", 115, 100, 1'b1, 0, RED);
        pix("off.out", 116, 100, 1'b0, 0, BG);
        pix("off.negx", 85, 100, 1'b1, 0, RED);
        pix("off.negy", 100, 85, 1'b1, 0, RED);
        wr(2, 1'b1, 1000, 1000, 2040, GRN, w);
        frame(31);
        pix("sat", 0, 0, 1'b1, 2, GRN);

        // Shadow isolation
        wr(2, 1'b0, 1000, 1000, 2040, GRN, w);
        frame(5);
        wr(0, 1'b1, 100, 100, 50, RED, w);
        pix("shd.old", 130, 100, 1'b0, 0, BG);
        frame(0);
        pix("shd.new", 130, 100, 1'b1, 0, RED);
        bus.i_cfg_valid    = 1'b1;
        bus.i_cfg_idx      = 3'd0;
        bus.i_cfg_en       = 1'b1;
        bus.i_cfg_radius   = 11'd10;
        bus.i_cfg_color    = RED;
        bus.i_frame_start  = 1'b1;
        bus.i_radius_off   = 5'd0;
        tick();
        bus.i_cfg_valid    = 1'b0;
        bus.i_frame_start  = 1'b0;
        pix("shd.coinc", 130, 100, 1'b1, 0, RED);
        frame(0);
        pix("shd.late", 130, 100, 1'b0, 0, BG);
        pix("shd.late.in", 110, 100, 1'b1, 0, RED);

        // Zero radius lights only the centre
        wr(0, 1'b1, 100, 100, 0, RED, w);
        frame(0);
        pix("r0.ctr", 100, 100, 1'b1, 0, RED);
        pix("r0.right", 101, 100, 1'b0, 0, BG);
        pix("r0.left", 99, 100, 1'b0, 0, BG);

        // Clear with a coincident (dropped) write
        bus.i_cfg_clear    = 1'b1;
        bus.i_cfg_valid    = 1'b1;
        bus.i_cfg_idx      = 3'd1;
        bus.i_cfg_en       = 1'b1;
        bus.i_cfg_center_X = 11'd100;
        bus.i_cfg_center_Y = 11'd100;
        bus.i_cfg_radius   = 11'd20;
        bus.i_cfg_color    = GRN;
        tick();
        bus.i_cfg_clear    = 1'b0;
        bus.i_cfg_valid    = 1'b0;
        cnt = 0;
        while (!bus.o_cfg_ready && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("clr.len", 32'(cnt), 32'd8);
        frame(0);
        pix("clr.ctr", 100, 100, 1'b0, 0, BG);
        pix("clr.far", 200, 200, 1'b0, 0, BG);

        // Write issued during clear stalls until ready returns
        bus.i_cfg_clear = 1'b1;
        tick();
        bus.i_cfg_clear = 1'b0;
        wr(4, 1'b1, 200, 200, 5, BLU, w);
        chk("clr.stall", 32'(w), 32'd8);
        frame(0);
        pix("clr.wr", 200, 200, 1'b1, 4, BLU);
        pix("clr.bg", 100, 100, 1'b0, 0, BG);

        // Reset during a continuous pixel stream
        bus.i_pix_valid = 1'b1;
        bus.i_VGA_X     = 11'd200;
        bus.i_VGA_Y     = 11'd200;
        repeat (4) tick();
        chk("mid.vld", 32'(bus.o_pix_valid), 32'd1);
        chk("mid.idx", 32'(bus.o_hit_idx), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.vld", 32'(bus.o_pix_valid), 32'd0);
        chk("mrst.hit", 32'(bus.o_hit), 32'd0);
        chk("mrst.idx", 32'(bus.o_hit_idx), 32'd0);
        chk("mrst.rgb", 32'({bus.o_VGA_R, bus.o_VGA_G, bus.o_VGA_B}), 32'd0);
        chk("mrst.ready", 32'(bus.o_cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (!bus.o_pix_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("mrst.lat", 32'(cnt), 32'd3);
        chk("mrst.nohit", 32'(bus.o_hit), 32'd0);
        chk("mrst.bg", 32'({bus.o_VGA_R, bus.o_VGA_G, bus.o_VGA_B}), 32'(BG));
        bus.i_pix_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
